// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter
// Shares one 5x5 sprite rasteriser (and the VGA write port behind it) among
// NREQ requesters using round-robin arbitration. The winner's start
// coordinates and sprite select are latched, the rasteriser is enabled until
// it flags its last pixel, then the winner gets a one-cycle done pulse.
//
// Ports
//   clock        system clock, all state on posedge
//   reset        asynchronous active-low reset
//   req          level request per requester
//   req_x        start x per requester, requester i at [8i+7:8i]
//   req_y        start y per requester, requester i at [7i+6:7i]
//   req_sprite   sprite select per requester
//   grant        one-hot, high for the whole draw of the winner
//   done         one-cycle pulse to the served requester
//   drw_en       rasteriser enable / VGA plot
//   drw_startx   latched start x
//   drw_starty   latched start y
//   drw_sprite   latched sprite select
//   drw_done     rasteriser last-pixel flag
//   busy         high in any state other than IDLE
//   wd_err       sticky watchdog flag
//
// Build option: define SPRITE_ARB_WATCHDOG_EN to compile in a draw watchdog
// that forces the draw to end after WD_LIMIT cycles and sets wd_err.
// Without it DRAW waits indefinitely and wd_err is tied 0.

module sprite_draw_arbiter #(
   parameter int NREQ     = 4,
   parameter int SPR_W    = 3,
   parameter int WD_LIMIT = 63
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [8*NREQ-1:0]     req_x,
   input  logic [7*NREQ-1:0]     req_y,
   input  logic [SPR_W*NREQ-1:0] req_sprite,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  drw_en,
   output logic [7:0]            drw_startx,
   output logic [6:0]            drw_starty,
   output logic [SPR_W-1:0]      drw_sprite,
   input  logic                  drw_done,
   output logic                  busy,
   output logic                  wd_err
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [PTR_W-1:0] ptr_r, ptr_s;
   logic [PTR_W-1:0] winner_r, winner_s;
   logic [PTR_W-1:0] pick_s;
   logic             found_s;
   logic [NREQ-1:0]  grant_r, grant_s;
   logic [NREQ-1:0]  done_r, done_s;
   logic             drw_en_r, drw_en_s;
   logic [7:0]       startx_r, startx_s;
   logic [6:0]       starty_r, starty_s;
   logic [SPR_W-1:0] sprite_r, sprite_s;
   logic             busy_r, busy_s;
   logic             timeout_s;
   logic             finish_s;

   // Round-robin pick: first set request bit scanning upward from ptr, wrapping.
   always_comb begin
      int idx;
      found_s = 1'b0;
      pick_s  = '0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr_r) + i) % NREQ;
         if (!found_s && req[idx]) begin
            found_s = 1'b1;
            pick_s  = PTR_W'(idx);
         end else begin
            found_s = found_s;
         end
      end
   end

`ifdef SPRITE_ARB_WATCHDOG_EN
   logic [5:0] wd_cnt_r, wd_cnt_s;
   logic       wd_err_r, wd_err_s;

   // Timeout fires on the DRAW cycle where WD_LIMIT enabled cycles have elapsed.
   assign timeout_s = (state_r == ST_DRAW) && (wd_cnt_r == 6'(WD_LIMIT - 1));

   // Watchdog next state: count only while a draw is still running.
   always_comb begin
      wd_cnt_s = 6'd0;
      wd_err_s = wd_err_r;
      if ((state_r == ST_DRAW) && !finish_s) begin
         wd_cnt_s = wd_cnt_r + 6'd1;
      end else begin
         wd_cnt_s = 6'd0;
      end
      if (timeout_s && !drw_done) begin
         wd_err_s = 1'b1;
      end else begin
         wd_err_s = wd_err_r;
      end
   end

   // Watchdog registers; wd_err is sticky until reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt_r <= 6'd0;
         wd_err_r <= 1'b0;
      end else begin
         wd_cnt_r <= wd_cnt_s;
         wd_err_r <= wd_err_s;
      end
   end

   assign wd_err = wd_err_r;
`else
   assign timeout_s = 1'b0;
   assign wd_err    = 1'b0;
`endif

   // A rasteriser completion or a watchdog timeout both end the draw.
   assign finish_s = drw_done | timeout_s;

   // FSM next-state and next-output logic; all outputs are registered.
   always_comb begin
      state_s  = state_r;
      ptr_s    = ptr_r;
      winner_s = winner_r;
      grant_s  = grant_r;
      done_s   = '0;
      drw_en_s = drw_en_r;
      startx_s = startx_r;
      starty_s = starty_r;
      sprite_s = sprite_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s  = ST_DRAW;
               winner_s = pick_s;
               grant_s  = ONE_HOT0 << pick_s;
               drw_en_s = 1'b1;
               startx_s = req_x[8*int'(pick_s) +: 8];
               starty_s = req_y[7*int'(pick_s) +: 7];
               sprite_s = req_sprite[SPR_W*int'(pick_s) +: SPR_W];
            end else begin
               grant_s  = '0;
               drw_en_s = 1'b0;
               startx_s = 8'd0;
               starty_s = 7'd0;
               sprite_s = '0;
            end
         end
         ST_DRAW: begin
            // req and req_* are deliberately ignored for the rest of the draw.
            if (finish_s) begin
               state_s  = ST_REL;
               grant_s  = '0;
               drw_en_s = 1'b0;
               done_s   = ONE_HOT0 << winner_r;
               ptr_s    = (winner_r == PTR_W'(NREQ - 1)) ? '0 : winner_r + PTR_W'(1);
            end else begin
               state_s  = ST_DRAW;
            end
         end
         ST_REL: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s  = ST_IDLE;
            grant_s  = '0;
            drw_en_s = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         ptr_r    <= '0;
         winner_r <= '0;
         grant_r  <= '0;
         done_r   <= '0;
         drw_en_r <= 1'b0;
         startx_r <= 8'd0;
         starty_r <= 7'd0;
         sprite_r <= '0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         ptr_r    <= ptr_s;
         winner_r <= winner_s;
         grant_r  <= grant_s;
         done_r   <= done_s;
         drw_en_r <= drw_en_s;
         startx_r <= startx_s;
         starty_r <= starty_s;
         sprite_r <= sprite_s;
         busy_r   <= busy_s;
      end
   end

   assign grant      = grant_r;
   assign done       = done_r;
   assign drw_en     = drw_en_r;
   assign drw_startx = startx_r;
   assign drw_starty = starty_r;
   assign drw_sprite = sprite_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Directed self-checking bench for sprite_draw_arbiter (NREQ=4, SPR_W=3).
// Stimulus changes 1 time unit after each rising edge; outputs are sampled
// at the same point, well away from the active edge.

module tb_sprite_draw_arbiter;

   localparam int NREQ  = 4;
   localparam int SPR_W = 3;

   logic                  clock;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [8*NREQ-1:0]     req_x;
   logic [7*NREQ-1:0]     req_y;
   logic [SPR_W*NREQ-1:0] req_sprite;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  drw_en;
   logic [7:0]            drw_startx;
   logic [6:0]            drw_starty;
   logic [SPR_W-1:0]      drw_sprite;
   logic                  drw_done;
   logic                  busy;
   logic                  wd_err;

   int n_cmp = 0;
   int n_err = 0;

   sprite_draw_arbiter #(.NREQ(NREQ), .SPR_W(SPR_W), .WD_LIMIT(63)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_sprite (req_sprite),
      .grant      (grant),
      .done       (done),
      .drw_en     (drw_en),
      .drw_startx (drw_startx),
      .drw_starty (drw_starty),
      .drw_sprite (drw_sprite),
      .drw_done   (drw_done),
      .busy       (busy),
      .wd_err     (wd_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req = '0;
      drw_done = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Called right after the grant edge; returns just after the edge that
   // samples drw_done, so drw_en has been high for n cycles.
   task automatic run_draw(input int n);
      repeat (n - 1) tick();
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
   endtask

   task automatic set_coords(input int i, input logic [7:0] x, input logic [6:0] y,
                             input logic [SPR_W-1:0] s);
      req_x[8*i +: 8] = x;
      req_y[7*i +: 7] = y;
      req_sprite[SPR_W*i +: SPR_W] = s;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = 4'b1111;
      drw_done = 1'b1;
      #3;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b need %b", grant, 4'b0000); end
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done got %b need %b", done, 4'b0000); end
      n_cmp++; if (drw_en !== 1'b0) begin n_err++; $display("FAIL reset_drw_en got %b need 0", drw_en); end
      n_cmp++; if (drw_startx !== 8'd0 || drw_starty !== 7'd0 || drw_sprite !== 3'd0) begin n_err++; $display("FAIL reset_coords got %0d/%0d/%0d need 0/0/0", drw_startx, drw_starty, drw_sprite); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b need 0", busy); end
      n_cmp++; if (wd_err !== 1'b0) begin n_err++; $display("FAIL reset_wd_err got %b need 0", wd_err); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      set_coords(0, 8'd40, 7'd20, 3'd2);
      req = 4'b0001;
      tick();
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b need %b", grant, 4'b0001); end
      n_cmp++; if (drw_en !== 1'b1) begin n_err++; $display("FAIL single_drw_en got %b need 1", drw_en); end
      n_cmp++; if (drw_startx !== 8'd40) begin n_err++; $display("FAIL single_startx got %0d need 40", drw_startx); end
      n_cmp++; if (drw_starty !== 7'd20) begin n_err++; $display("FAIL single_starty got %0d need 20", drw_starty); end
      n_cmp++; if (drw_sprite !== 3'd2) begin n_err++; $display("FAIL single_sprite got %0d need 2", drw_sprite); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b need 1", busy); end
      repeat (29) tick();
      n_cmp++; if (drw_en !== 1'b1 || done !== 4'b0000) begin n_err++; $display("FAIL single_hold got en=%b done=%b need en=1 done=0000", drw_en, done); end
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      req = 4'b0000;
      n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL single_done got %b need %b", done, 4'b0001); end
      n_cmp++; if (drw_en !== 1'b0 || grant !== 4'b0000) begin n_err++; $display("FAIL single_release got en=%b grant=%b need 0/0000", drw_en, grant); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_rel_busy got %b need 1", busy); end
      tick();
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL single_done_clear got %b need 0000", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b need 0", busy); end
      // drw_done in IDLE must not produce a done pulse
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      n_cmp++; if (done !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL idle_drw_done got done=%b busy=%b need 0000/0", done, busy); end
   endtask

   task automatic test_two();
      do_reset();
      set_coords(1, 8'd11, 7'd21, 3'd5);
      set_coords(3, 8'd133, 7'd99, 3'd7);
      req = 4'b1010;
      tick();
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL two_first_grant got %b need %b", grant, 4'b0010); end
      n_cmp++; if (drw_startx !== 8'd11 || drw_starty !== 7'd21 || drw_sprite !== 3'd5) begin n_err++; $display("FAIL two_first_coords got %0d/%0d/%0d need 11/21/5", drw_startx, drw_starty, drw_sprite); end
      run_draw(5);
      req = 4'b1000;
      n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL two_first_done got %b need %b", done, 4'b0010); end
      // drw_done during REL is ignored
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      n_cmp++; if (grant !== 4'b0000 || done !== 4'b0000) begin n_err++; $display("FAIL two_gap got grant=%b done=%b need 0000/0000", grant, done); end
      tick();
      n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL two_second_grant got %b need %b", grant, 4'b1000); end
      n_cmp++; if (drw_startx !== 8'd133 || drw_starty !== 7'd99 || drw_sprite !== 3'd7) begin n_err++; $display("FAIL two_second_coords got %0d/%0d/%0d need 133/99/7", drw_startx, drw_starty, drw_sprite); end
      run_draw(5);
      req = 4'b0000;
      n_cmp++; if (done !== 4'b1000) begin n_err++; $display("FAIL two_second_done got %b need %b", done, 4'b1000); end
      tick();
   endtask

   task automatic test_all_rotation();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] xs [4] = '{8'd3, 8'd64, 8'd150, 8'd255};
      logic [6:0] ys [4] = '{7'd1, 7'd50, 7'd100, 7'd127};
      do_reset();
      for (int i = 0; i < NREQ; i++) set_coords(i, xs[i], ys[i], SPR_W'(i + 1));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++; if (grant !== (4'b0001 << order[k])) begin n_err++; $display("FAIL rot_grant[%0d] got %b need %b", k, grant, 4'b0001 << order[k]); end
         n_cmp++; if (drw_startx !== xs[order[k]] || drw_starty !== ys[order[k]] || drw_sprite !== SPR_W'(order[k] + 1)) begin n_err++; $display("FAIL rot_coords[%0d] got %0d/%0d/%0d need %0d/%0d/%0d", k, drw_startx, drw_starty, drw_sprite, xs[order[k]], ys[order[k]], order[k] + 1); end
         run_draw(3);
         n_cmp++; if (done !== (4'b0001 << order[k])) begin n_err++; $display("FAIL rot_done[%0d] got %b need %b", k, done, 4'b0001 << order[k]); end
         tick();
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_drop_mid_draw();
      do_reset();
      set_coords(2, 8'd77, 7'd33, 3'd4);
      req = 4'b0100;
      tick();
      n_cmp++; if (grant !== 4'b0100 || drw_startx !== 8'd77) begin n_err++; $display("FAIL drop_grant got grant=%b x=%0d need 0100/77", grant, drw_startx); end
      req = 4'b0000;
      req_x = {NREQ{8'd200}};
      req_y = {NREQ{7'd9}};
      repeat (4) tick();
      n_cmp++; if (drw_startx !== 8'd77 || drw_starty !== 7'd33 || grant !== 4'b0100 || drw_en !== 1'b1) begin n_err++; $display("FAIL drop_hold got x=%0d y=%0d grant=%b en=%b need 77/33/0100/1", drw_startx, drw_starty, grant, drw_en); end
      run_draw(3);
      n_cmp++; if (done !== 4'b0100) begin n_err++; $display("FAIL drop_done got %b need %b", done, 4'b0100); end
      tick();
   endtask

   task automatic test_reset_mid_draw();
      do_reset();
      set_coords(0, 8'd5, 7'd6, 3'd1);
      set_coords(2, 8'd90, 7'd45, 3'd3);
      req = 4'b0101;
      tick();
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant got %b need %b", grant, 4'b0001); end
      run_draw(4);
      req = 4'b0100;
      tick();
      tick();
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL rmid_second_grant got %b need %b", grant, 4'b0100); end
      repeat (9) tick();
      req = 4'b0101;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (drw_en !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_async got en=%b grant=%b busy=%b need 0/0000/0", drw_en, grant, busy); end
      reset = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b0001 || drw_startx !== 8'd5) begin n_err++; $display("FAIL rmid_ptr0 got grant=%b x=%0d need 0001/5", grant, drw_startx); end
      run_draw(2);
      req = 4'b0000;
      tick();
   endtask

`ifdef SPRITE_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      int n;
      do_reset();
      req = 4'b0001;
      tick();
      n = 1;
      while (drw_en === 1'b1 && n < 100) begin
         tick();
         if (drw_en === 1'b1) n++;
      end
      n_cmp++; if (n !== 63) begin n_err++; $display("FAIL wd_length got %0d need 63", n); end
      n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL wd_done got %b need %b", done, 4'b0001); end
      n_cmp++; if (wd_err !== 1'b1) begin n_err++; $display("FAIL wd_err_set got %b need 1", wd_err); end
      req = 4'b0010;
      tick();
      tick();
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL wd_next_grant got %b need %b", grant, 4'b0010); end
      run_draw(5);
      req = 4'b0000;
      n_cmp++; if (done !== 4'b0010 || wd_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky got done=%b wd_err=%b need 0010/1", done, wd_err); end
      tick();
   endtask
`endif

   initial begin
      reset = 1'b0;
      req = '0;
      req_x = '0;
      req_y = '0;
      req_sprite = '0;
      drw_done = 1'b0;
      test_reset();
      test_single();
      test_two();
      test_all_rotation();
      test_drop_mid_draw();
      test_reset_mid_draw();
`ifdef SPRITE_ARB_WATCHDOG_EN
      test_watchdog();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_draw_arbiter.md
# sprite_draw_arbiter

Shares the single 5x5 sprite rasteriser (and through it the VGA adapter write port) among up to NREQ sprite requesters: pac-man, ghosts and tile-erase. Round-robin arbitration; the winner's start coordinates and sprite select are latched, the rasteriser is enabled until it reports completion, and the requester receives a one-cycle done pulse. Sits between the game-logic FSMs and the rasteriser/VGA adapter.

## Interface
- NREQ, 4, number of requesters (2..8)
- SPR_W, 3, sprite-select width
- WD_LIMIT, 63, watchdog cycle limit (used only with the watchdog compiled in)

- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req  in  NREQ  level request, one bit per requester
- req_x  in  8*NREQ  start x, requester i at [8i+7:8i]
- req_y  in  7*NREQ  start y, requester i at [7i+6:7i]
- req_sprite  in  SPR_W*NREQ  sprite select per requester
- grant  out  NREQ  one-hot, high for the whole draw of the winner
- done  out  NREQ  one-cycle pulse to the served requester
- drw_en  out  1  rasteriser enable / VGA plot
- drw_startx  out  8  latched start x
- drw_starty  out  7  latched start y
- drw_sprite  out  SPR_W  latched sprite select
- drw_done  in  1  rasteriser last-pixel flag
- busy  out  1  high in any state other than IDLE
- wd_err  out  1  sticky watchdog flag (tied 0 without the watchdog)

## Operation
- States: IDLE, DRAW, REL.
- IDLE: when any req is high, pick the first set bit scanning from ptr upward, wrapping mod NREQ. Register grant, drw_startx/y, drw_sprite and drw_en=1, then go to DRAW. No requests: stay, all outputs 0.
- DRAW: hold drw_en and the latched values. The block ignores req and req_* changes; a requester dropping req mid-draw does not abort the draw, and its done still fires.
- drw_done sampled high in DRAW: drw_en=0, grant=0, done[winner]=1, ptr=winner+1 (mod NREQ), go to REL.
- REL: exactly one cycle, no arbitration; done clears on exit; go to IDLE.
- Requesters clear req on the edge that samples done; a still-high req after REL is treated as a new request.
- Coordinates pass through unmodified; no clipping or width conversion.
- Reset (any time, including mid-DRAW): state=IDLE, ptr=0, and grant, done, drw_en, drw_startx, drw_starty, drw_sprite, busy and wd_err all 0. A partly drawn sprite stays on screen.

## Timing
- Req high before edge k with the block in IDLE: grant and drw_en are high after edge k (1-cycle latency).
- Draw length is set by the rasteriser. A 5x5 sprite holds drw_en for 30 cycles, until drw_done is sampled.
- drw_done sampled at edge m: done is high from m to m+1; earliest next grant after edge m+2.
- Back-to-back service period = draw cycles + 2.
- drw_done while in IDLE or REL: ignored.
- Simultaneous requests: strict rotation; no requester waits more than NREQ-1 draws.

## Configuration
- SPRITE_ARB_WATCHDOG_EN defined:
  - A 6-bit counter runs in DRAW.
  - If WD_LIMIT cycles pass without drw_done, the block forces the DRAW exit (drw_en=0, done pulse, ptr advance) and sets wd_err.
  - wd_err stays set until reset.
- Macro undefined:
  - No counter; DRAW waits indefinitely.
  - wd_err is tied 0.

## Test plan
- Single request, req[0] at x=40, y=20, sprite=2 -> grant=0001 and drw_en high after the next edge; drw_startx=40, drw_starty=20, drw_sprite=2; done[0] pulses exactly one cycle after drw_done; busy is low two edges later.
- req[1] and req[3] raised in the same cycle, ptr=0 -> req[1] served first, then req[3]; two done pulses, 2-cycle gap between draws.
- All four requests held continuously -> grant order 0,1,2,3,0; each draw latches its own requester's coordinates.
- req[2] dropped mid-DRAW while req_x changes -> drw_startx unchanged, the draw completes, done[2] pulses.
- Reset asserted at cycle 10 of a draw -> drw_en, grant and busy are 0 immediately, with no clock edge; after release, pending req[0] is granted with ptr=0.
- Watchdog build, drw_done held 0 -> drw_en drops after 63 cycles, done pulses, wd_err=1 and stays set across further normal draws.
